// File: rtl/sample_writer_pkg.sv
// Shared definitions for the sample memory writer: state encoding and default widths.
package sample_writer_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sample_writer_addr_counter.sv
// Write-address counter for one block: clear, enable, and a flag on the
// increment that brings the count to DEPTH.
module write_addr_counter
    import sample_writer_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = 256
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            enable,
    output logic [ADDR_W:0] count,
    output logic            terminal
);

    localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(DEPTH - 1);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // One bit wider than the address so a full 2^ADDR_W block is representable.
    assign terminal = enable && (count == LAST);

endmodule

// File: rtl/sample_writer.sv
// Writer side of the sample RAM: streams bytes to addresses 0..DEPTH-1 and pulses done.
// Optional running checksum output enabled by defining SAMPLE_WRITER_CHECKSUM_EN.
module sample_writer
    import sample_writer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done
`ifdef SAMPLE_WRITER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    state_t state;
    state_t state_next;
    logic   start_fill;
    logic   accept;
    logic   terminal;

    assign start_fill = (state == IDLE) && start;
    // Abort outranks a coinciding handshake: the sample is dropped.
    assign accept     = in_valid && in_ready && !abort;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a latch behind.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (abort) begin
                    state_next = IDLE;
                end else if (terminal) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = !abort;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    write_addr_counter #(
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) u_addr_counter (
        .clk     (clk),
        .rst     (rst),
        .clear   (start_fill),
        .enable  (accept),
        .count   (count),
        .terminal(terminal)
    );

    // Address and data hold between writes so the RAM port stays quiet.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= accept;
            if (accept) begin
                mem_addr  <= count[ADDR_W-1:0];
                mem_wdata <= in_data;
            end
        end
    end

`ifdef SAMPLE_WRITER_CHECKSUM_EN
    logic [DATA_W-1:0] sum;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sum <= '0;
        end else if (start_fill) begin
            sum <= '0;
        end else if (accept) begin
            sum <= sum + in_data;
        end
    end

    assign checksum = sum;
`endif

endmodule

// File: doc/sample_writer.md
Name: sample_writer

Overview:
- Writer side of the sample memory that the averaging datapath reads by counter address.
- Accepts bytes over a valid/ready stream and writes them to consecutive memory addresses starting at 0.
- Reports completion with a one-cycle pulse so the averaging controller can start its read/accumulate pass.
- Sits between the sample source and the write port of the sample RAM.

Parameters:
- DATA_W, 8, sample width; matches the averaging datapath width.
- ADDR_W, 8, memory address width.
- DEPTH, 256, samples per block; requires 1 <= DEPTH <= 2^ADDR_W.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; synchronous, active-low.
- start  input  1  pulse that begins a block fill; sampled only in IDLE.
- abort  input  1  ends the fill and returns to IDLE; highest priority after rst.
- in_valid  input  1  source presents in_data.
- in_data  input  DATA_W  sample byte.
- in_ready  output  1  writer can accept a sample this cycle.
- mem_we  output  1  write strobe to the RAM (registered).
- mem_addr  output  ADDR_W  write address (registered).
- mem_wdata  output  DATA_W  write data (registered).
- count  output  ADDR_W+1  samples accepted in the current or last block.
- busy  output  1  high in LOAD and DONE.
- done  output  1  one-cycle pulse when the final write of a block has been issued.

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE.
  - in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, count=0, busy=0, done=0.
  - A reset mid-fill discards progress and issues no further writes.
- States: IDLE, LOAD, DONE.
- IDLE:
  - in_ready=0.
  - If start=1: go to LOAD and clear count to 0.
  - Otherwise count holds its last value.
- LOAD:
  - in_ready=1.
  - A sample is accepted on a cycle with in_valid && in_ready.
  - On accept, next cycle: mem_we=1, mem_addr=count[ADDR_W-1:0], mem_wdata=in_data; count increments.
  - Latency from accept to mem_we is exactly 1 cycle.
  - mem_we=0 on any cycle after a non-accepting cycle.
  - Gaps in in_valid are allowed; the address advances only on accepts.
  - On the accept that makes count reach DEPTH, go to DONE. in_ready is 0 in the following cycle.
- DONE:
  - Lasts exactly 1 cycle; the final mem_we=1 occurs in this cycle.
  - done=1 for this cycle only, then go to IDLE.
  - count holds at DEPTH until the next start.
- Start handling:
  - start is ignored in LOAD and DONE.
  - start in the same cycle as done does not begin a new fill; the next fill needs start in IDLE.
- abort:
  - In LOAD or DONE: go to IDLE next cycle; done is not asserted.
  - A write already registered from the accept in the abort cycle does not occur: mem_we is forced to 0 in the cycle after abort.
  - count holds its value at the abort.
  - In IDLE, abort has no effect.
- Simultaneous abort and an accept: abort wins; the sample is dropped and count does not increment.
- Addresses never wrap within a block because DEPTH <= 2^ADDR_W.
- When DEPTH=2^ADDR_W, count reaches 2^ADDR_W, using its MSB.
- mem_addr and mem_wdata hold their last values when mem_we=0.

Optional Feature:
- Macro: SAMPLE_WRITER_CHECKSUM_EN.
- With the macro defined:
  - Extra output checksum [DATA_W-1:0] is a modulo-2^DATA_W running sum of the accepted samples.
  - The sum clears on start and on reset, and updates in the same cycle as mem_we.
  - Its value is valid when done=1, so the bench can cross-check the reader's accumulator.
- Without the macro: no checksum port and no adder logic.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, LOAD=2'd1, DONE=2'd2) and default widths (DATA_W, ADDR_W).
- One natural sub-module: write_addr_counter, an ADDR_W+1-bit counter with clear, enable, and a terminal-count flag at DEPTH.
- FSM and output registers stay in the top module.

Test Plan:
- Reset then idle: hold rst=0 for 2 cycles, release -> all outputs 0; in_valid=1 with no start -> no mem_we, count=0.
- Full block, DEPTH=4, continuous valid, data 8'h10,8'h20,8'h30,8'h40:
  - mem_we cycles write addr 0..3 with that data, each 1 cycle after its accept.
  - done pulses once, in the same cycle as the addr-3 write; count=4.
  - With checksum enabled: checksum=8'hA0.
- Gapped valid, DEPTH=4: in_valid toggles 1,0,1,1,0,1 -> exactly 4 writes at consecutive addresses; mem_we low after each gap cycle; done pulses once.
- Abort mid-fill, DEPTH=8: abort after 3 accepts, with an accept in the abort cycle -> 3 writes only; no done; count=3; state IDLE. A new start clears count to 0.
- Start ignored: start pulsed during LOAD and in the done cycle -> no restart; after IDLE a fresh start begins a new block at addr 0.
- Reset mid-fill, DEPTH=8: rst=0 after 5 accepts -> next cycle mem_we=0, count=0, busy=0; no done is ever pulsed.
